// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave bridging to a single-port synchronous SRAM
//   hclk/hresetn           : clock, asynchronous active-low reset
//   hsel/haddr/htrans      : address phase select, byte address, transfer type
//   hsize/hwrite/hwdata    : transfer size, direction, data-phase write data
//   hrdata/hready/hresp    : read data, stall/done, error response
//   mem_ce/mem_we/mem_addr : SRAM strobe, write enable, word address
//   mem_be/mem_wdata       : SRAM byte enables, write data
//   mem_rdata              : SRAM read data, valid the cycle after a read strobe
module ahb_sram_slave #(
  parameter int AWIDTH = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic [3:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hready,
  output logic              hresp,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, WR, ERR1, ERR2} state_t;
  state_t              state;
  logic [2:0]          cnt;
  logic [AWIDTH+1:0]   addr_q;
  logic [1:0]          size_q;
  logic                pend;
  logic                rdv;
  logic [31:0]         hold;
  logic                last;
  logic                accept;
  logic                err;
  logic                wr_commit;
  logic                coll;
  logic                rd_now;
  logic                unused;
  assign unused = ^{haddr[31:24], htrans[0]};
  assign last = (state == RD || state == WR) && cnt == 3'd0;
  assign hready = state == IDLE || state == ERR2 || last;
  assign hresp = state == ERR1 || state == ERR2;
  // Reset gates acceptance so no read strobe can leak out while hresetn is low.
  assign accept = hresetn && hsel && htrans[1] && hready;
  assign err = (|haddr[23:AWIDTH+2]) || hsize > 4'd2 || (hsize == 4'd1 && haddr[0]) || (hsize == 4'd2 && |haddr[1:0]);
  assign wr_commit = state == WR && last;
  // A read accepted while a write owns the SRAM port is deferred one cycle.
  assign coll = accept && !err && !hwrite && wr_commit;
  assign rd_now = accept && !err && !hwrite && !wr_commit;
  assign mem_ce = wr_commit || rd_now || pend;
  assign mem_we = wr_commit;
  assign mem_addr = rd_now ? haddr[AWIDTH+1:2] : addr_q[AWIDTH+1:2];
  assign mem_wdata = hwdata;
  assign mem_be = wr_commit ? ((size_q == 2'd0 ? 4'b0001 : size_q == 2'd1 ? 4'b0011 : 4'b1111) << addr_q[1:0]) : 4'b0000;
  // Read data is only live when it arrives; otherwise it comes from the hold register.
  assign hrdata = (state == RD && last) ? (rdv ? mem_rdata : hold) : 32'h0;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
      cnt <= 3'd0;
      addr_q <= '0;
      size_q <= 2'd0;
      pend <= 1'b0;
      rdv <= 1'b0;
      hold <= 32'h0;
    end else begin
      rdv <= mem_ce && !mem_we;
      pend <= coll;
      if (rdv) hold <= mem_rdata;
      if (accept) begin
        addr_q <= haddr[AWIDTH+1:0];
        size_q <= hsize[1:0];
        state <= err ? ERR1 : hwrite ? WR : RD;
        cnt <= err ? 3'd0 : 3'(WAIT_STATES) + {2'b00, coll};
      end else if (state == ERR1) state <= ERR2;
      else if (state == ERR2 || last) state <= IDLE;
      else if (cnt != 3'd0) cnt <= cnt - 3'd1;
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: scoreboard bench for ahb_sram_slave with zero and two wait states
module tb_ahb_sram_slave;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [3:0]  hsize = 4'd0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic        use2 = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] hrdata0, hrdata1, hrdata, wd0, wd1, m_wdata;
  logic        hready0, hready1, hready, hresp0, hresp1, hresp;
  logic        ce0, ce1, m_ce, we0, we1, m_we;
  logic [9:0]  ad0, ad1, m_addr;
  logic [3:0]  be0, be1, m_be;
  logic [31:0] mem [0:1023];
  bit          loaded = 1'b0;
  typedef struct {bit err; bit rd; logic [31:0] data; int waits;} exp_t;
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ce_cnt = 0;
  logic [3:0]  lw_be = 4'h0;
  logic [9:0]  lw_addr = 10'h0;
  bit          active = 1'b0;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.AWIDTH(10), .WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel && !use2), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0),
    .hresp(hresp0), .mem_ce(ce0), .mem_we(we0), .mem_addr(ad0), .mem_be(be0),
    .mem_wdata(wd0), .mem_rdata(mem_rdata));

  ahb_sram_slave #(.AWIDTH(10), .WAIT_STATES(2)) u1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel && use2), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata1), .hready(hready1),
    .hresp(hresp1), .mem_ce(ce1), .mem_we(we1), .mem_addr(ad1), .mem_be(be1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata));

  assign hrdata = use2 ? hrdata1 : hrdata0;
  assign hready = use2 ? hready1 : hready0;
  assign hresp = use2 ? hresp1 : hresp0;
  assign m_ce = use2 ? ce1 : ce0;
  assign m_we = use2 ? we1 : we0;
  assign m_addr = use2 ? ad1 : ad0;
  assign m_be = use2 ? be1 : be0;
  assign m_wdata = use2 ? wd1 : wd0;

  always @(posedge hclk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
      loaded <= 1'b1;
    end else begin
      if (m_ce && m_we)
        for (int b = 0; b < 4; b++) if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      if (m_ce && !m_we) mem_rdata <= mem[m_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t cur;
    int wc;
    wc = 0;
    forever begin
      @(negedge hclk);
      if (m_ce) ce_cnt++;
      if (m_ce && m_we) begin
        lw_be = m_be;
        lw_addr = m_addr;
      end
      if (!hresetn) active = 1'b0;
      else begin
        if (active) begin
          if (!hready) begin
            wc++;
            chk("hresp_wait", 32'(hresp), 32'(cur.err));
            chk("hrdata_wait_zero", hrdata, 32'h0);
          end else begin
            chk("wait_cycles", wc, cur.waits);
            chk("hresp_final", 32'(hresp), 32'(cur.err));
            chk(cur.rd ? "hrdata_final" : "hrdata_nonread_zero", hrdata, cur.rd ? cur.data : 32'h0);
            active = 1'b0;
          end
        end
        if (hsel && htrans[1] && hready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got accept expected none at %0t", $time);
          end else begin
            cur = q.pop_front();
            active = 1'b1;
            wc = 0;
          end
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input bit w, input logic [3:0] sz, input logic [31:0] wd,
                      input bit er, input logic [31:0] d, input int wt);
    exp_t e;
    int n;
    e.err = er;
    e.rd = !w && !er;
    e.data = d;
    e.waits = wt;
    q.push_back(e);
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = a;
    hwrite = w;
    hsize = sz;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!hready && n < 50);
    chk("accept_ready", 32'(hready), 32'h1);
    @(posedge hclk);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  initial begin
    int c0;
    #12;
    chk("rst_hready", 32'(hready0), 32'h1);
    chk("rst_hresp", 32'(hresp0), 32'h0);
    chk("rst_hrdata", hrdata0, 32'h0);
    chk("rst_mem_ce", 32'(ce0), 32'h0);
    chk("rst_mem_be", 32'(be0), 32'h0);
    chk("rst_hready_ws2", 32'(hready1), 32'h1);
    #10;
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    xfer(32'h2000_0010, 1, 4'd2, 32'hDEAD_BEEF, 0, 32'h0, 0);
    xfer(32'h2000_0010, 0, 4'd2, 32'h0, 0, 32'hDEAD_BEEF, 1);
    idle(3);
    xfer(32'h2000_0013, 1, 4'd0, 32'hAB00_0000, 0, 32'h0, 0);
    xfer(32'h2000_0010, 0, 4'd2, 32'h0, 0, 32'hABAD_BEEF, 1);
    idle(3);
    chk("byte_be", 32'(lw_be), 32'h8);
    chk("byte_addr", 32'(lw_addr), 32'h4);
    c0 = ce_cnt;
    xfer(32'h2000_0001, 1, 4'd1, 32'h1111_1111, 1, 32'h0, 1);
    idle(3);
    xfer(32'h2000_1000, 0, 4'd2, 32'h0, 1, 32'h0, 1);
    xfer(32'h2000_0000, 0, 4'd3, 32'h0, 1, 32'h0, 1);
    xfer(32'h2000_0006, 0, 4'd2, 32'h0, 1, 32'h0, 1);
    idle(4);
    chk("err_no_mem_ce", ce_cnt, c0);
    xfer(32'h2000_0012, 0, 4'd1, 32'h0, 0, 32'hABAD_BEEF, 0);
    xfer(32'h2000_0020, 0, 4'd2, 32'h0, 0, 32'hA500_0008, 0);
    xfer(32'h2000_0011, 0, 4'd0, 32'h0, 0, 32'hABAD_BEEF, 0);
    idle(2);
    xfer(32'h2000_0026, 1, 4'd1, 32'h5678_0000, 0, 32'h0, 0);
    xfer(32'h2000_0024, 0, 4'd2, 32'h0, 0, 32'h5678_0009, 1);
    idle(3);
    chk("half_be", 32'(lw_be), 32'hC);
    chk("half_addr", 32'(lw_addr), 32'h9);
    c0 = ce_cnt;
    hsel = 1'b1;
    htrans = 2'b00;
    haddr = 32'h2000_0020;
    hwrite = 1'b0;
    hsize = 4'd2;
    @(negedge hclk);
    chk("idle_trans_hready", 32'(hready), 32'h1);
    chk("idle_trans_mem_ce", 32'(m_ce), 32'h0);
    @(posedge hclk);
    #1;
    hsel = 1'b0;
    @(negedge hclk);
    chk("idle_trans_no_phase", 32'(hready), 32'h1);
    chk("idle_trans_no_access", ce_cnt, c0);
    idle(1);
    use2 = 1'b1;
    idle(1);
    xfer(32'h0000_0000, 0, 4'd2, 32'h0, 0, 32'hA500_0000, 2);
    xfer(32'h0000_0004, 0, 4'd2, 32'h0, 0, 32'hA500_0001, 2);
    idle(5);
    xfer(32'h0000_0008, 1, 4'd2, 32'hCAFE_F00D, 0, 32'h0, 2);
    xfer(32'h0000_0008, 0, 4'd2, 32'h0, 0, 32'hCAFE_F00D, 3);
    idle(6);
    q.push_back('{0, 0, 32'h0, 2});
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = 32'h0000_0040;
    hwrite = 1'b1;
    hsize = 4'd2;
    @(negedge hclk);
    @(posedge hclk);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h1234_5678;
    chk("wr_wait1_hready", 32'(hready), 32'h0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("mid_rst_hready", 32'(hready), 32'h1);
    chk("mid_rst_mem_ce", 32'(m_ce), 32'h0);
    chk("mid_rst_hresp", 32'(hresp), 32'h0);
    q.push_back('{0, 1, 32'hA500_0010, 2});
    hsel = 1'b1;
    htrans = 2'b10;
    haddr = 32'h0000_0040;
    hwrite = 1'b0;
    hsize = 4'd2;
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    @(negedge hclk);
    @(posedge hclk);
    #1;
    hsel = 1'b0;
    htrans = 2'b00;
    idle(6);
    chk("rst_mem_unchanged", mem[16], 32'hA500_0010);
    chk("queue_drained", q.size(), 32'h0);
    chk("no_phase_open", 32'(active), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
